// File: rtl/dat_mem_arbiter_if.sv
// Request/ack bundle for the two clients of dat_mem_arbiter (A = MEM stage, B = debug/DMA loader).
// Handshake: the client raises req with we/addr/wdata and holds them stable until it sees ack;
// ack is a single-cycle registered pulse, and rdata is valid during that pulse after a read.
interface dat_mem_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              a_req;
    logic              a_we;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_wdata;
    logic              a_ack;
    logic [DATA_W-1:0] a_rdata;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic              b_ack;
    logic [DATA_W-1:0] b_rdata;

    logic              busy;
    logic [1:0]        fsm_state;

    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        output a_ack, a_rdata, b_ack, b_rdata, busy, fsm_state
    );

    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        input  a_ack, a_rdata, b_ack, b_rdata, busy, fsm_state
    );
endinterface

// File: rtl/dat_mem_arbiter.sv
// Round-robin arbiter and sequencer placing two req/ack clients onto one synchronous
// single-port data memory; owns chip select, write enable, address and dat bus turnaround.
module dat_mem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    dat_mem_arbiter_if.slave   port,
    output logic               mem_chipSel,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_addr,
    inout  wire  [DATA_W-1:0]  mem_dat
);
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR       = 2'd1,
        RD_ISSUE = 2'd2,
        RD_CAP   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    state_t            state;
    state_t            state_nxt;
    port_t             gnt;
    port_t             last_gnt;
    logic [DATA_W-1:0] wdata_q;
    logic              a_ack_q;
    logic              b_ack_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    logic a_elig;
    logic b_elig;
    logic grant;
    logic grant_b;
    logic done;

    // A port whose ack is high this cycle is retiring its request, so it is masked out.
    assign a_elig = port.a_req && !a_ack_q;
    assign b_elig = port.b_req && !b_ack_q;

    always_comb begin
        state_nxt   = state;
        grant       = 1'b0;
        grant_b     = 1'b0;
        done        = 1'b0;
        mem_chipSel = 1'b0;
        mem_write   = 1'b0;
        case (state)
            IDLE: begin
                if (a_elig || b_elig) begin
                    grant   = 1'b1;
                    grant_b = b_elig && (!a_elig || (last_gnt == PORT_A));
                    if (grant_b ? port.b_we : port.a_we) state_nxt = WR;
                    else                                 state_nxt = RD_ISSUE;
                end
            end
            WR: begin
                mem_chipSel = 1'b1;
                mem_write   = 1'b1;
                done        = 1'b1;
                state_nxt   = IDLE;
            end
            RD_ISSUE: begin
                mem_chipSel = 1'b1;
                state_nxt   = RD_CAP;
            end
            RD_CAP: begin
                mem_chipSel = 1'b1;
                done        = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= PORT_A;
            last_gnt  <= PORT_B;
            mem_addr  <= '0;
            wdata_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state   <= state_nxt;
            a_ack_q <= done && (gnt == PORT_A);
            b_ack_q <= done && (gnt == PORT_B);
            if (state == RD_CAP) begin
                if (gnt == PORT_A) a_rdata_q <= mem_dat;
                else               b_rdata_q <= mem_dat;
            end
            if (grant) begin
                gnt      <= grant_b ? PORT_B : PORT_A;
                last_gnt <= grant_b ? PORT_B : PORT_A;
                mem_addr <= grant_b ? port.b_addr  : port.a_addr;
                wdata_q  <= grant_b ? port.b_wdata : port.a_wdata;
            end
        end
    end

    // The memory owns the bus in every state except WR.
    assign mem_dat = (state == WR) ? wdata_q : {DATA_W{1'bz}};

    assign port.a_ack     = a_ack_q;
    assign port.b_ack     = b_ack_q;
    assign port.a_rdata   = a_rdata_q;
    assign port.b_rdata   = b_rdata_q;
    assign port.busy      = (state != IDLE);
    assign port.fsm_state = state;
endmodule

// File: tb/tb_dat_mem_arbiter.sv
// Bench for dat_mem_arbiter: a behavioural synchronous memory on the pins, per-scenario tasks
// and a word-level reference memory driving expected read data.
module tb_dat_mem_arbiter;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mem_chipSel;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  wire  [DATA_W-1:0] mem_dat;

  dat_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  dat_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .port        (bus),
    .mem_chipSel (mem_chipSel),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_dat     (mem_dat)
  );

  always #5 clk = ~clk;

  // Synchronous memory: registers DM[addr] on a read select and drives it the next selected cycle.
  logic [DATA_W-1:0] mem_arr [256];
  logic [DATA_W-1:0] rd_q;
  logic              rd_en_q;
  logic              mem_oe;

  initial for (int i = 0; i < 256; i++) mem_arr[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_5A5A;

  always @(posedge clk) begin
    if (mem_chipSel && mem_write) mem_arr[mem_addr] <= mem_dat;
    if (mem_chipSel && !mem_write) rd_q <= mem_arr[mem_addr];
    rd_en_q <= mem_chipSel && !mem_write;
  end

  assign mem_oe  = rd_en_q && mem_chipSel && !mem_write;
  assign mem_dat = mem_oe ? rd_q : {DATA_W{1'bz}};

  logic [DATA_W-1:0] ref_mem [256];
  int checks = 0;
  int fails  = 0;

  task automatic do_op(input bit is_b, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wdata, output logic [DATA_W-1:0] rdata,
                       output int lat, output bit timed_out);
    logic ack;
    @(negedge clk);
    if (is_b) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
    lat = 0;
    ack = 1'b0;
    while (!ack && lat < 20) begin
      @(negedge clk);
      lat++;
      ack = is_b ? bus.b_ack : bus.a_ack;
    end
    timed_out = !ack;
    rdata = is_b ? bus.b_rdata : bus.a_rdata;
    if (is_b) bus.b_req = 1'b0;
    else      bus.a_req = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (mem_chipSel !== 1'b0) begin fails++; $display("FAIL reset_chipsel: got %b, expected 0", mem_chipSel); end
    checks++; if (mem_write !== 1'b0) begin fails++; $display("FAIL reset_write: got %b, expected 0", mem_write); end
    checks++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_addr: got %h, expected 00", mem_addr); end
    checks++; if ({bus.a_ack, bus.b_ack} !== 2'b00) begin fails++; $display("FAIL reset_acks: got %b, expected 00", {bus.a_ack, bus.b_ack}); end
    checks++; if (bus.a_rdata !== 32'h0) begin fails++; $display("FAIL reset_a_rdata: got %h, expected 0", bus.a_rdata); end
    checks++; if (bus.b_rdata !== 32'h0) begin fails++; $display("FAIL reset_b_rdata: got %h, expected 0", bus.b_rdata); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", bus.busy); end
    rst_n = 1'b1;
  endtask

  // Both ports hold reads; grants alternate starting with firstp, each read takes 3 cycles.
  task automatic tie_reads(input string name, input bit first_b,
                           input logic [ADDR_W-1:0] a_addr, input logic [ADDR_W-1:0] b_addr);
    bit exp_a, exp_b;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = a_addr;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = b_addr;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      exp_a = first_b ? (i % 6 == 0) : (i % 6 == 3);
      exp_b = first_b ? (i % 6 == 3) : (i % 6 == 0);
      checks++; if (bus.a_ack !== exp_a) begin fails++; $display("FAIL %s a_ack cycle %0d: got %b, expected %b", name, i, bus.a_ack, exp_a); end
      checks++; if (bus.b_ack !== exp_b) begin fails++; $display("FAIL %s b_ack cycle %0d: got %b, expected %b", name, i, bus.b_ack, exp_b); end
      if (exp_a) begin
        checks++; if (bus.a_rdata !== ref_mem[a_addr]) begin fails++; $display("FAIL %s a_rdata: got %h, expected %h", name, bus.a_rdata, ref_mem[a_addr]); end
      end
      if (exp_b) begin
        checks++; if (bus.b_rdata !== ref_mem[b_addr]) begin fails++; $display("FAIL %s b_rdata: got %h, expected %h", name, bus.b_rdata, ref_mem[b_addr]); end
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    // Fresh out of reset, A wins the first tie.
    tie_reads("round_robin", 1'b0, 8'h40, 8'h41);
  endtask

  task automatic test_write_read_latency();
    logic [DATA_W-1:0] rd;
    int lat;
    bit to;
    int n;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h10; bus.a_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++; if ({mem_chipSel, mem_write} !== 2'b11) begin fails++; $display("FAIL wr_pins: got %b, expected 11", {mem_chipSel, mem_write}); end
    checks++; if (mem_addr !== 8'h10) begin fails++; $display("FAIL wr_addr: got %h, expected 10", mem_addr); end
    checks++; if (mem_dat !== 32'hDEAD_BEEF) begin fails++; $display("FAIL wr_dat: got %h, expected deadbeef", mem_dat); end
    checks++; if (bus.busy !== 1'b1) begin fails++; $display("FAIL wr_busy: got %b, expected 1", bus.busy); end
    checks++; if (bus.a_ack !== 1'b0) begin fails++; $display("FAIL wr_early_ack: got %b, expected 0", bus.a_ack); end
    @(negedge clk);
    checks++; if (bus.a_ack !== 1'b1) begin fails++; $display("FAIL wr_ack_cycle2: got %b, expected 1", bus.a_ack); end
    bus.a_req = 1'b0;
    ref_mem[8'h10] = 32'hDEAD_BEEF;
    n = 0;
    do_op(1'b0, 1'b0, 8'h10, 32'h0, rd, lat, to);
    checks++; if (to) begin fails++; $display("FAIL rd_timeout: got no ack, expected ack"); end
    checks++; if (lat !== 3) begin fails++; $display("FAIL rd_latency: got %0d, expected 3", lat); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin fails++; $display("FAIL rd_data: got %h, expected deadbeef", rd); end
  endtask

  task automatic test_handoff();
    int n;
    bit overlap;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h20; bus.a_wdata = 32'h1;
    n = 0;
    overlap = 1'b0;
    while (!bus.a_ack && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_write && mem_oe) overlap = 1'b1;
    end
    checks++; if (n !== 2) begin fails++; $display("FAIL handoff_a_latency: got %0d, expected 2", n); end
    ref_mem[8'h20] = 32'h1;
    // B raises its read inside A's ack cycle.
    bus.a_req = 1'b0;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 8'h20;
    n = 0;
    while (!bus.b_ack && n < 20) begin
      @(negedge clk);
      n++;
      if (mem_write && mem_oe) overlap = 1'b1;
    end
    bus.b_req = 1'b0;
    checks++; if (n !== 3) begin fails++; $display("FAIL handoff_b_latency: got %0d, expected 3", n); end
    checks++; if (bus.b_rdata !== 32'h1) begin fails++; $display("FAIL handoff_b_rdata: got %h, expected 1", bus.b_rdata); end
    checks++; if (overlap !== 1'b0) begin fails++; $display("FAIL handoff_bus_overlap: got %b, expected 0", overlap); end
  endtask

  task automatic test_edges();
    logic [DATA_W-1:0] rd;
    int lat;
    bit to;
    do_op(1'b0, 1'b1, 8'h00, 32'hFFFF_FFFF, rd, lat, to);
    checks++; if (to) begin fails++; $display("FAIL edge_wr00_timeout: got no ack, expected ack"); end
    ref_mem[8'h00] = 32'hFFFF_FFFF;
    do_op(1'b1, 1'b1, 8'hFF, 32'h0, rd, lat, to);
    checks++; if (to) begin fails++; $display("FAIL edge_wrff_timeout: got no ack, expected ack"); end
    ref_mem[8'hFF] = 32'h0;
    do_op(1'b0, 1'b0, 8'hFF, 32'h0, rd, lat, to);
    checks++; if (rd !== ref_mem[8'hFF]) begin fails++; $display("FAIL edge_rd_ff: got %h, expected %h", rd, ref_mem[8'hFF]); end
    do_op(1'b1, 1'b0, 8'h00, 32'h0, rd, lat, to);
    checks++; if (rd !== ref_mem[8'h00]) begin fails++; $display("FAIL edge_rd_00: got %h, expected %h", rd, ref_mem[8'h00]); end
    checks++; if (bus.a_rdata !== ref_mem[8'hFF]) begin fails++; $display("FAIL edge_a_rdata_kept: got %h, expected %h", bus.a_rdata, ref_mem[8'hFF]); end
  endtask

  task automatic test_reset_mid_write();
    bit ack_seen;
    @(negedge clk);
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 8'h30; bus.a_wdata = 32'h1234_5678;
    @(negedge clk);
    checks++; if (mem_write !== 1'b1) begin fails++; $display("FAIL rstwr_in_wr: got %b, expected 1", mem_write); end
    rst_n = 1'b0;
    bus.a_req = 1'b0;
    #1;
    checks++; if ({mem_chipSel, mem_write} !== 2'b00) begin fails++; $display("FAIL rstwr_pins: got %b, expected 00", {mem_chipSel, mem_write}); end
    checks++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rstwr_busy: got %b, expected 0", bus.busy); end
    ack_seen = 1'b0;
    repeat (2) begin @(negedge clk); if (bus.a_ack || bus.b_ack) ack_seen = 1'b1; end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (bus.a_ack || bus.b_ack) ack_seen = 1'b1; end
    checks++; if (ack_seen !== 1'b0) begin fails++; $display("FAIL rstwr_ack: got %b, expected 0", ack_seen); end
    // ref_mem[0x30] is untouched; reset also restores A-first tie breaking.
    tie_reads("rstwr_readback", 1'b0, 8'h30, 8'h31);
  endtask

  task automatic port_thread(input bit is_b, input int n_ops);
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] wd;
    logic [ADDR_W-1:0] addr;
    bit we;
    int lat;
    bit to;
    for (int k = 0; k < n_ops; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      we   = 1'($urandom_range(0, 1));
      addr = {is_b, 7'($urandom_range(0, 127))};
      wd   = $urandom;
      do_op(is_b, we, addr, wd, rd, lat, to);
      checks++;
      if (to || lat < (we ? 2 : 3) || lat > 6) begin
        fails++; $display("FAIL rand_latency port %0d op %0d: got %0d, expected %0d..6", is_b, k, lat, we ? 2 : 3);
      end
      if (we) ref_mem[addr] = wd;
      else begin
        checks++; if (rd !== ref_mem[addr]) begin fails++; $display("FAIL rand_rdata port %0d addr %h: got %h, expected %h", is_b, addr, rd, ref_mem[addr]); end
      end
    end
  endtask

  task automatic test_random();
    fork
      port_thread(1'b0, 25);
      port_thread(1'b1, 25);
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_5A5A;
    bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
    test_reset();
    test_round_robin();
    test_write_read_latency();
    test_handoff();
    test_edges();
    test_reset_mid_write();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
